// File: rtl/mem_asym_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_asym_pkg
// Purpose  : Shared definitions for the asymmetric-width RAM: port-mode
//            encodings, controller state type and a constant clog2 helper.
// Revision : 1.0  initial release
// ============================================================================
package mem_asym_pkg;

  // Port-width arrangement selected by the MODE parameter
  localparam int MODE_WIDE_WR   = 0;  // wide write port, narrow read port
  localparam int MODE_NARROW_WR = 1;  // narrow write port, wide read port

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Address width for a given depth; never returns less than 1 so that
  // single-entry memories still get a legal port.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_asym_lane.sv
`default_nettype none
// ============================================================================
// Module   : mem_asym_lane
// Purpose  : One narrow lane of the asymmetric RAM: W x DEPTH storage with
//            its own write enable and an unregistered read port. The parent
//            registers the read data, which gives read-first behaviour.
// Revision : 1.0  initial release
// ============================================================================
module mem_asym_lane #(
  parameter int W     = 9,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Lane storage write; callers guarantee the address is in range
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mem_asym_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_asym_ram
// Purpose  : Single-clock RAM with one wide port and one narrow port
//            (RATIO narrow lanes per wide word). MODE picks which side
//            writes. Optional output register, optional zero-fill after
//            reset, read-first on same-word collisions, out-of-range writes
//            dropped and out-of-range reads return zero.
//            RATIO must be 1, 2 or 4 and divide WIDE_W.
// Revision : 1.0  initial release
// ============================================================================
module mem_asym_ram
  import mem_asym_pkg::*;
#(
  parameter int WIDE_W     = 18,
  parameter int RATIO      = 2,
  parameter int WIDE_DEPTH = 512,
  parameter int MODE       = 0,
  parameter int PIPE       = 1,
  parameter int CLEAR_EN   = 1,
  localparam int NARROW_W     = WIDE_W / RATIO,
  localparam int NARROW_DEPTH = WIDE_DEPTH * RATIO,
  localparam int WIDE_AW      = clog2(WIDE_DEPTH),
  localparam int NARROW_AW    = clog2(NARROW_DEPTH),
  localparam int WA_W = (MODE == MODE_WIDE_WR) ? WIDE_AW   : NARROW_AW,
  localparam int RA_W = (MODE == MODE_WIDE_WR) ? NARROW_AW : WIDE_AW,
  localparam int WD_W = (MODE == MODE_WIDE_WR) ? WIDE_W    : NARROW_W,
  localparam int RD_W = (MODE == MODE_WIDE_WR) ? NARROW_W  : WIDE_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [WA_W-1:0] waddr,
  input  logic [WD_W-1:0] wdata,
  input  logic            re,
  input  logic [RA_W-1:0] raddr,
  output logic [RD_W-1:0] q,
  output logic            q_valid,
  output logic            init_busy
);

  localparam logic [WIDE_AW-1:0] c_CLR_LAST = WIDE_AW'(WIDE_DEPTH - 1);

  // Controller
  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDE_AW-1:0]   r_clr_cnt;
  logic [WIDE_AW-1:0]   w_clr_cnt_nxt;
  logic                 w_clr;
  logic                 w_ready;

  // Write side, decoded to wide word + lane enables
  logic [WIDE_AW-1:0]   w_wr_word;
  logic [RATIO-1:0]     w_wr_lane_en;
  logic                 w_wr_ok;
  logic [WIDE_W-1:0]    w_wr_data;
  logic                 w_wr_fire;

  // Read side
  logic [WIDE_AW-1:0]   w_rd_word;
  logic                 w_rd_ok;
  logic [RD_W-1:0]      w_rd_sel;
  logic                 w_rd_fire;

  // Lane connections
  logic                 w_lane_we    [RATIO];
  logic [WIDE_AW-1:0]   w_lane_waddr;
  logic [NARROW_W-1:0]  w_lane_wdata [RATIO];
  logic [NARROW_W-1:0]  w_lane_q     [RATIO];

  // Read pipeline stage 1 (always present)
  logic                 r_s1_vld;
  logic [RD_W-1:0]      r_s1_data;

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------

  // State and clear-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state logic: one IDLE cycle, then a zero-fill sweep of every wide
  // word (if enabled), then normal operation
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr         = 1'b0;
    w_ready       = 1'b0;
    init_busy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clr_cnt_nxt = '0;
        w_state_nxt   = (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        w_clr     = 1'b1;
        init_busy = 1'b1;
        if (r_clr_cnt == c_CLR_LAST) begin
          w_clr_cnt_nxt = '0;
          w_state_nxt   = ST_READY;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      ST_READY: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  if (MODE == MODE_WIDE_WR) begin : g_wide_wr
    assign w_wr_word    = waddr;
    assign w_wr_ok      = (32'(waddr) < WIDE_DEPTH);
    assign w_wr_lane_en = '1;
    assign w_wr_data    = wdata;
  end else begin : g_narrow_wr
    logic [1:0] w_wr_lane;
    assign w_wr_word = WIDE_AW'(32'(waddr) / RATIO);
    assign w_wr_lane = 2'(32'(waddr) % RATIO);
    assign w_wr_ok   = (32'(waddr) < NARROW_DEPTH);
    // The narrow word is presented on every lane; only one lane is enabled
    assign w_wr_data = {RATIO{wdata}};
    for (genvar i = 0; i < RATIO; i++) begin : g_wr_en
      assign w_wr_lane_en[i] = (w_wr_lane == 2'(i));
    end
  end

  if (MODE == MODE_WIDE_WR) begin : g_narrow_rd
    logic [1:0] w_rd_lane;
    assign w_rd_word = WIDE_AW'(32'(raddr) / RATIO);
    assign w_rd_lane = 2'(32'(raddr) % RATIO);
    assign w_rd_ok   = (32'(raddr) < NARROW_DEPTH);
    // Pick the addressed lane out of the wide word
    always_comb begin
      w_rd_sel = '0;
      for (int i = 0; i < RATIO; i++) begin
        if (w_rd_lane == 2'(i)) begin
          w_rd_sel = w_lane_q[i];
        end
      end
    end
  end else begin : g_wide_rd
    assign w_rd_word = raddr;
    assign w_rd_ok   = (32'(raddr) < WIDE_DEPTH);
    for (genvar i = 0; i < RATIO; i++) begin : g_rd_cat
      assign w_rd_sel[i*NARROW_W +: NARROW_W] = w_lane_q[i];
    end
  end

  assign w_wr_fire = we & w_ready & w_wr_ok;
  assign w_rd_fire = re & w_ready;

  // ---------------------------------------------------------------------
  // Storage lanes; the clear sweep overrides the user write port
  // ---------------------------------------------------------------------
  assign w_lane_waddr = w_clr ? r_clr_cnt : w_wr_word;

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign w_lane_we[i]    = w_clr | (w_wr_fire & w_wr_lane_en[i]);
    assign w_lane_wdata[i] = w_clr ? '0 : w_wr_data[i*NARROW_W +: NARROW_W];

    mem_asym_lane #(
      .W     (NARROW_W),
      .DEPTH (WIDE_DEPTH),
      .AW    (WIDE_AW)
    ) u_lane (
      .clk     (clk),
      .i_we    (w_lane_we[i]),
      .i_waddr (w_lane_waddr),
      .i_wdata (w_lane_wdata[i]),
      .i_raddr (w_rd_word),
      .o_rdata (w_lane_q[i])
    );
  end

  // ---------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------

  // Stage 1 captures pre-write data; data is only updated when a read fires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd_fire;
      if (w_rd_fire) begin
        r_s1_data <= w_rd_ok ? w_rd_sel : '0;
      end
    end
  end

  if (PIPE != 0) begin : g_pipe1
    logic            r_s2_vld;
    logic [RD_W-1:0] r_s2_data;

    // Optional output register stage, holding q between reads
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s2_vld  <= 1'b0;
        r_s2_data <= '0;
      end else begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign q       = r_s2_data;
    assign q_valid = r_s2_vld;
  end else begin : g_pipe0
    assign q       = r_s1_data;
    assign q_valid = r_s1_vld;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_asym_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_asym_ram
// Purpose  : Directed self-checking bench for mem_asym_ram across four
//            configurations sharing one clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_asym_ram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u0: defaults (MODE 0, RATIO 2, 18-bit, 512 words, PIPE 1)
  logic        d0_we, d0_re, d0_qv, d0_busy;
  logic [8:0]  d0_waddr;
  logic [17:0] d0_wdata;
  logic [9:0]  d0_raddr;
  logic [8:0]  d0_q;

  // u1: MODE 1, RATIO 4, 32-bit, 512 words
  logic        d1_we, d1_re, d1_qv, d1_busy;
  logic [10:0] d1_waddr;
  logic [7:0]  d1_wdata;
  logic [8:0]  d1_raddr;
  logic [31:0] d1_q;

  // u2: MODE 0, 300 words
  logic        d2_we, d2_re, d2_qv, d2_busy;
  logic [8:0]  d2_waddr;
  logic [17:0] d2_wdata;
  logic [9:0]  d2_raddr;
  logic [8:0]  d2_q;

  // u3: MODE 1, 300 words, PIPE 0
  logic        d3_we, d3_re, d3_qv, d3_busy;
  logic [9:0]  d3_waddr;
  logic [8:0]  d3_wdata;
  logic [8:0]  d3_raddr;
  logic [17:0] d3_q;

  mem_asym_ram u0 (
    .clk(clk), .rst(rst), .we(d0_we), .waddr(d0_waddr), .wdata(d0_wdata),
    .re(d0_re), .raddr(d0_raddr), .q(d0_q), .q_valid(d0_qv), .init_busy(d0_busy)
  );

  mem_asym_ram #(.WIDE_W(32), .RATIO(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .we(d1_we), .waddr(d1_waddr), .wdata(d1_wdata),
    .re(d1_re), .raddr(d1_raddr), .q(d1_q), .q_valid(d1_qv), .init_busy(d1_busy)
  );

  mem_asym_ram #(.WIDE_DEPTH(300)) u2 (
    .clk(clk), .rst(rst), .we(d2_we), .waddr(d2_waddr), .wdata(d2_wdata),
    .re(d2_re), .raddr(d2_raddr), .q(d2_q), .q_valid(d2_qv), .init_busy(d2_busy)
  );

  mem_asym_ram #(.WIDE_DEPTH(300), .MODE(1), .PIPE(0)) u3 (
    .clk(clk), .rst(rst), .we(d3_we), .waddr(d3_waddr), .wdata(d3_wdata),
    .re(d3_re), .raddr(d3_raddr), .q(d3_q), .q_valid(d3_qv), .init_busy(d3_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; everything is driven and sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b_vals [4];
  int         waited;
  int         n_busy;
  logic       saw_qv;

  initial begin
    b_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    d0_we = 0; d0_re = 0; d0_waddr = '0; d0_wdata = '0; d0_raddr = '0;
    d1_we = 0; d1_re = 0; d1_waddr = '0; d1_wdata = '0; d1_raddr = '0;
    d2_we = 0; d2_re = 0; d2_waddr = '0; d2_wdata = '0; d2_raddr = '0;
    d3_we = 0; d3_re = 0; d3_waddr = '0; d3_wdata = '0; d3_raddr = '0;

    // Reset state
    repeat (2) tick();
    check("rst_q0",    d0_q,    0);
    check("rst_qv0",   d0_qv,   0);
    check("rst_busy0", d0_busy, 0);
    check("rst_q1",    d1_q,    0);
    rst = 1'b0;

    // First edge after release: IDLE -> CLEAR
    tick();
    check("busy_rise", d0_busy, 1);
    waited = 0;
    while ((d0_busy | d1_busy | d2_busy | d3_busy) && waited < 2000) begin
      tick();
      waited++;
    end
    check("init_done", {d0_busy, d1_busy, d2_busy, d3_busy}, 0);

    // u0: wide write 0x2ABCD to word 5, narrow reads 10 and 11.
    // Lane 0 = bits[8:0] = 0x1CD, lane 1 = bits[17:9] = 0x155.
    d0_we = 1; d0_waddr = 5; d0_wdata = 18'h2ABCD;
    tick();
    d0_we = 0;
    d0_re = 1; d0_raddr = 10;
    tick();
    check("lat_not_yet", d0_qv, 0);
    d0_raddr = 11;
    tick();
    check("n10_q", d0_q,  9'h1CD);
    check("n10_v", d0_qv, 1);
    d0_re = 0;
    tick();
    check("n11_q", d0_q,  9'h155);
    check("n11_v", d0_qv, 1);
    tick();
    check("hold_q", d0_q,  9'h155);
    check("hold_v", d0_qv, 0);

    // u0: read-first collision on word 3 (old 0x00001, new 0x3FFFF)
    d0_we = 1; d0_waddr = 3; d0_wdata = 18'h00001;
    tick();
    d0_wdata = 18'h3FFFF; d0_re = 1; d0_raddr = 6;
    tick();
    d0_we = 0; d0_raddr = 7;
    tick();
    check("rf_old", d0_q, 9'h001);
    d0_re = 0;
    tick();
    check("rf_new", d0_q, 9'h1FF);

    // u1: narrow writes 0x11..0x44 to narrow 0..3, wide read of word 0
    for (int i = 0; i < 4; i++) begin
      d1_we = 1; d1_waddr = 11'(i); d1_wdata = b_vals[i];
      tick();
    end
    d1_we = 0;
    d1_re = 1; d1_raddr = 0;
    tick();
    d1_re = 0;
    tick();
    check("wide0", d1_q, 32'h44332211);
    // Narrow write to lane 2 only
    d1_we = 1; d1_waddr = 2; d1_wdata = 8'hAB;
    tick();
    d1_we = 0;
    d1_re = 1; d1_raddr = 0;
    tick();
    d1_re = 0;
    tick();
    check("lane2_only", d1_q, 32'h44AB2211);

    // u2: 300 words; write to word 300 dropped, word 299 = 0x12345.
    // Narrow 598 -> 0x145, 599 -> 0x091, 600 (out of range) -> 0.
    d2_we = 1; d2_waddr = 300; d2_wdata = 18'h3FFFF;
    tick();
    d2_waddr = 299; d2_wdata = 18'h12345;
    tick();
    d2_we = 0;
    d2_re = 1; d2_raddr = 598;
    tick();
    d2_raddr = 599;
    tick();
    check("n598", d2_q, 9'h145);
    d2_raddr = 600;
    tick();
    check("n599", d2_q, 9'h091);
    d2_re = 0;
    tick();
    check("n600_q", d2_q,  0);
    check("n600_v", d2_qv, 1);

    // u3: PIPE 0, out-of-range narrow write then 16 narrow writes,
    // followed by 8 back-to-back wide reads at latency 1
    d3_we = 1; d3_waddr = 600; d3_wdata = 9'h1FF;
    tick();
    for (int i = 0; i < 16; i++) begin
      d3_waddr = 10'(i); d3_wdata = 9'(i * 17 + 1);
      tick();
    end
    d3_we = 0;
    for (int k = 0; k < 8; k++) begin
      d3_re = 1; d3_raddr = 9'(k);
      tick();
      check("b2b_v", d3_qv, 1);
      check("b2b_q", d3_q, {9'((2 * k + 1) * 17 + 1), 9'(2 * k * 17 + 1)});
    end
    d3_re = 0;
    tick();
    check("b2b_end", d3_qv, 0);

    // Reset with a read in flight: q clears and the read is never delivered
    d0_re = 1; d0_raddr = 10;
    tick();
    d0_re = 0;
    rst = 1'b1;
    #1;
    check("arst_q",  d0_q,  0);
    check("arst_qv", d0_qv, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    repeat (100) tick();
    check("mid_clear", d0_busy, 1);

    // Reset mid-clear, then hammer the ports while the sweep restarts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d0_we = 1; d0_waddr = 5; d0_wdata = 18'h3FFFF;
    d0_re = 1; d0_raddr = 10;
    n_busy = 0;
    saw_qv = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 10) begin
        d0_we = 0;
        d0_re = 0;
      end
      tick();
      if (d0_qv) saw_qv = 1'b1;
      if (d0_busy) n_busy++;
      else if (n_busy > 0) break;
    end
    check("clr_len",  n_busy, 512);
    check("clr_noqv", saw_qv, 0);

    // Words 3 and 5 held data before; all must read zero now
    for (int i = 0; i < 4; i++) begin
      d0_re = 1;
      case (i)
        0: d0_raddr = 10;
        1: d0_raddr = 11;
        2: d0_raddr = 6;
        default: d0_raddr = 7;
      endcase
      tick();
      d0_re = 0;
      tick();
      check("clr_zero_q", d0_q,  0);
      check("clr_zero_v", d0_qv, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
